// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one operand bit per clock, WIDTH RUN cycles, done pulse in cycle WIDTH+1.
// Optional build macro MULDIV_SIGNED_EN enables two's-complement operation via the sign port.
module mul_div_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             div_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mq_q, mq_d;
   logic               neg_q_q, neg_q_d;
   logic               neg_r_q, neg_r_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic               dz_q, dz_d;

   logic               sgn_in;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_acc_n, mul_mq_n;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic [WIDTH-1:0]   div_acc_n, div_mq_n;
   logic [WIDTH-1:0]   step_acc, step_mq;

   logic [2*WIDTH-1:0] prod_mag, prod_fin;
   logic [WIDTH-1:0]   quo_fin, rem_fin;

`ifdef MULDIV_SIGNED_EN
   assign sgn_in = sign;
`else
   logic unused_sign;
   assign unused_sign = sign;
   assign sgn_in      = 1'b0;
`endif

   // Operands are iterated as magnitudes; the sign is reapplied on the way out.
   assign a_neg = sgn_in & a[WIDTH-1];
   assign b_neg = sgn_in & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Shift-add multiply: {acc, mq} holds the partial product, mq starts as the multiplier.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      mul_acc_n = mul_sum[WIDTH:1];
      mul_mq_n  = {mul_sum[0], mq_q[WIDTH-1:1]};
   end

   // Restoring divide: acc is the partial remainder, mq shifts dividend out and quotient in.
   always_comb begin
      div_shift = {acc_q, mq_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, b_q};
      if (!div_diff[WIDTH+1]) begin
         div_acc_n = div_diff[WIDTH-1:0];
         div_mq_n  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
         div_acc_n = div_shift[WIDTH-1:0];
         div_mq_n  = {mq_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      step_acc = op_q[1] ? div_acc_n : mul_acc_n;
      step_mq  = op_q[1] ? div_mq_n  : mul_mq_n;
      prod_mag = {mul_acc_n, mul_mq_n};
      prod_fin = neg_q_q ? -prod_mag : prod_mag;
      quo_fin  = neg_q_q ? -div_mq_n : div_mq_n;
      rem_fin  = neg_r_q ? -div_acc_n : div_acc_n;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      b_d      = b_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      carry_d  = carry_q;
      dz_d     = dz_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               op_d    = op;
               b_d     = b_mag;
               acc_d   = '0;
               mq_d    = a_mag;
               cnt_d   = '0;
               neg_q_d = a_neg ^ b_neg;
               neg_r_d = a_neg;
               ovf_d   = sgn_in & op[1] & (a == MIN_VAL) & (&b);
               dz_d    = 1'b0;
               if (op[1] && (b == '0)) begin
                  // Divide by zero bypasses iteration entirely.
                  state_d  = DONE;
                  result_d = op[0] ? a : '1;
                  carry_d  = 1'b1;
                  dz_d     = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            mq_d  = step_mq;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               case (op_q)
                  2'b00: begin
                     result_d = prod_fin[WIDTH-1:0];
                     carry_d  = |prod_fin[2*WIDTH-1:WIDTH];
                  end
                  2'b01: begin
                     result_d = prod_fin[2*WIDTH-1:WIDTH];
                     carry_d  = 1'b0;
                  end
                  2'b10: begin
                     result_d = quo_fin;
                     carry_d  = ovf_q;
                  end
                  default: begin
                     result_d = rem_fin;
                     carry_d  = ovf_q;
                  end
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         ovf_q    <= ovf_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         dz_q     <= dz_d;
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign result   = result_q;
   assign carry    = carry_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=16); signed vectors only when MULDIV_SIGNED_EN is defined.
module tb_mul_div_unit;

   localparam int W    = 16;
   localparam int MAXC = 40;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic         sign;
   logic [W-1:0] a, b;
   logic         busy, done, carry, div_zero;
   logic [W-1:0] result;

   int n_chk  = 0;
   int n_fail = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .sign     (sign),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carry    (carry),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge of cycle 1.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      op = o; a = x; b = y; sign = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts cycles from the current negedge (k=1) until done is seen.
   task automatic wait_done(output int lat, output int nbusy);
      lat = 0; nbusy = 0;
      for (int k = 1; k <= MAXC; k++) begin
         if (done) begin
            lat = k;
            break;
         end
         if (busy) nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic run_chk(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic s, input logic [W-1:0] exp_res,
                          input logic exp_c, input logic exp_dz, input int exp_lat);
      int lat, nb;
      issue(o, x, y, s);
      wait_done(lat, nb);
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy cycles"}, nb, exp_lat - 1);
      chk({tag, " busy at done"}, busy, 1'b0);
      chk({tag, " result"}, result, exp_res);
      chk({tag, " carry"}, carry, exp_c);
      chk({tag, " div_zero"}, div_zero, exp_dz);
      @(negedge clk);
      chk({tag, " done one cycle"}, done, 1'b0);
      chk({tag, " result held"}, result, exp_res);
   endtask

   initial begin
      int lat, nb, ndone;
      reset = 1'b1; start = 1'b0; op = 2'b00; sign = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset result", result, 16'h0000);
      chk("reset carry", carry, 1'b0);
      chk("reset div_zero", div_zero, 1'b0);
      @(negedge clk);

      run_chk("mul lo 1234x10", 2'b00, 16'h1234, 16'h0010, 1'b0, 16'h2340, 1'b1, 1'b0, 17);
      run_chk("mul hi ffffxffff", 2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 1'b0, 17);
      run_chk("mul lo ffffxffff", 2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, 17);
      run_chk("div0 quo", 2'b10, 16'h00AB, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1);
      run_chk("div0 rem", 2'b11, 16'h00AB, 16'h0000, 1'b0, 16'h00AB, 1'b1, 1'b1, 1);
      run_chk("div 100/7", 2'b10, 16'd100, 16'd7, 1'b0, 16'd14, 1'b0, 1'b0, 17);
      run_chk("rem 100%7", 2'b11, 16'd100, 16'd7, 1'b0, 16'd2, 1'b0, 1'b0, 17);
      run_chk("mul lo 0x0", 2'b00, 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0, 17);
      run_chk("div 5/9", 2'b10, 16'd5, 16'd9, 1'b0, 16'd0, 1'b0, 1'b0, 17);

      // Reset mid-run aborts without a done pulse.
      issue(2'b00, 16'h1234, 16'h0010, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort result", result, 16'h0000);
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("abort no done", ndone, 0);
      run_chk("mul after abort 3x5", 2'b00, 16'd3, 16'd5, 1'b0, 16'd15, 1'b0, 1'b0, 17);

      // Start pulse during RUN is ignored; start in DONE is accepted back-to-back.
      issue(2'b00, 16'd9, 16'd9, 1'b0);
      repeat (3) @(negedge clk);
      op = 2'b01; a = 16'd1; b = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, nb);
      chk("ignored start latency", lat, 13);
      chk("ignored start result", result, 16'd81);
      issue(2'b00, 16'd6, 16'd7, 1'b0);
      wait_done(lat, nb);
      chk("b2b latency", lat, 17);
      chk("b2b result", result, 16'd42);
      chk("b2b carry", carry, 1'b0);
      @(negedge clk);
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      chk("b2b no extra done", ndone, 0);

`ifdef MULDIV_SIGNED_EN
      run_chk("sdiv -7/2", 2'b10, 16'hFFF9, 16'd2, 1'b1, 16'hFFFD, 1'b0, 1'b0, 17);
      run_chk("srem -7%2", 2'b11, 16'hFFF9, 16'd2, 1'b1, 16'hFFFF, 1'b0, 1'b0, 17);
      run_chk("smul hi -2x3", 2'b01, 16'hFFFE, 16'd3, 1'b1, 16'hFFFF, 1'b0, 1'b0, 17);
      run_chk("sdiv min/-1", 2'b10, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0, 17);
      run_chk("srem min/-1", 2'b11, 16'h8000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 17);
`else
      run_chk("sign ignored div", 2'b10, 16'hFFF9, 16'd2, 1'b1, 16'h7FFC, 1'b0, 1'b0, 17);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multi-cycle multiply/divide unit that extends the CPU's single-cycle ALU with MUL and DIV class operations. It is parametrised in datapath width and processes one operand bit per clock. The CPU drives it with a start/busy/done handshake and stalls its pipeline while busy is high. The result and carry flag are written back to the register file and carry_flag in the same way as ALU results.

Parameters:
WIDTH, 16, operand/result width in bits (>= 4); iteration count equals WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE state
op  input  2  00 MUL low half, 01 MUL high half, 10 DIV quotient, 11 DIV remainder
sign  input  1  signed-operation select; honoured only with MULDIV_SIGNED_EN
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high while iterating
done  output  1  single-cycle pulse: result, carry and div_zero are valid
result  output  WIDTH  selected result half, quotient or remainder; held until the next accepted start
carry  output  1  flag written to the CPU carry_flag
div_zero  output  1  high when the last DIV op had b == 0

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (sync): state=IDLE, iteration counter=0, busy=0, done=0, result=0, carry=0, div_zero=0. Reset during RUN aborts the operation; no done pulse is produced and the operands are discarded.
- IDLE: start=1 latches a, b, op and sign, clears the counter, and moves to RUN. start=0 stays in IDLE.
- RUN: busy=1. Each cycle performs one shift-add step (MUL) or one restoring shift-subtract step (DIV). After exactly WIDTH RUN cycles the unit moves to DONE.
- DONE: lasts one cycle with done=1 and busy=0. The outputs update on entry to DONE. start=1 in DONE is accepted and goes straight to RUN (back-to-back ops); otherwise the unit returns to IDLE.
- Latency: start high in cycle 0 gives busy in cycles 1..WIDTH and done in cycle WIDTH+1.
- start while in RUN is ignored; operand changes during RUN have no effect.
- Width rules:
  - MUL forms a 2*WIDTH product internally.
  - op=00 returns bits [WIDTH-1:0], carry=1 iff the high half is nonzero (overflow).
  - op=01 returns bits [2*WIDTH-1:WIDTH], carry=0.
  - DIV ops: carry=0.
- div_zero is cleared by any accepted start; it is set only by a DIV op with b==0.
- Divide by zero (op=1x, b==0):
  - RUN is skipped: IDLE/DONE goes to DONE, so done appears in cycle 1.
  - Quotient = all ones, remainder = a, div_zero=1, carry=1.
- Outputs are stable outside DONE; result is never X after reset.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: sign=1 treats a and b as two's complement.
  - Magnitudes are iterated, then the result is conditionally negated.
  - MUL high returns the signed high half.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - MIN / -1 returns quotient=MIN, remainder=0, carry=1.
  - Latency is unchanged (WIDTH+1).
- Undefined: the sign port is ignored and all ops are unsigned. The port stays present so the interface is identical in both builds.

Test Plan:
- WIDTH=16; start, op=00, a=0x1234, b=0x0010 -> done in cycle 17 only, result=0x2340, carry=1; busy high in cycles 1..16.
- op=01, a=0xFFFF, b=0xFFFF -> result=0xFFFE, carry=0. Repeat with op=00 -> result=0x0001, carry=1.
- op=10, a=100, b=7 -> result=14, div_zero=0. op=11, same operands -> result=2, carry=0.
- op=10, a=0x00AB, b=0 -> done in cycle 1, result=0xFFFF, div_zero=1, carry=1. Then op=11 with the same operands -> result=0x00AB.
- Reset in cycle 5 of a MUL -> busy=0 next cycle, no done pulse, result=0. Then start op=00, a=3, b=5 -> result=15 at cycle 17.
- Pulse start during RUN -> ignored, exactly one done. Start high in the DONE cycle with a=6, b=7, op=00 -> second done 17 cycles later, result=42. With MULDIV_SIGNED_EN, sign=1, op=10, a=0xFFF9 (-7), b=2 -> result=0xFFFD (-3). Same operands with op=11 -> result=0xFFFF (-1).
